uart_tx_arbiter: RTL and testbench

Byte-level arbiter and serializer that shares the single board TXD pin between the CPU UART and the on-chip debugger (OCD). Each requester hands over whole bytes through a valid/ready handshake. Ownership of the line changes only at frame boundaries, so no character is ever truncated or interleaved. The block sits between the MCU/OCD byte sources and the TXD pad, in place of the per-cycle output mux.

---
 rtl/uart_tx_arbiter.sv | 88 ++++++++
 tb/tb_uart_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 TXD pin between CPU and OCD byte sources, switching owner only between frames
module uart_tx_arbiter #(
    parameter int BAUD_PERIOD = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sel_ocd1_cpu0,
    input  logic       cpu_tx_valid,
    input  logic [7:0] cpu_tx_data,
    output logic       cpu_tx_ready,
    input  logic       ocd_tx_valid,
    input  logic [7:0] ocd_tx_data,
    output logic       ocd_tx_ready,
    output logic       TXD,
    output logic       busy,
    output logic       grant_ocd
);
    localparam int CW = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_PERIOD - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] idx_q, idx_d;
    logic txd_q, txd_d;
    logic grant_q, grant_d;
    logic idle, ocd_win, cpu_win, hs, tick;
    assign idle         = (state_q == IDLE) & reset_n;
    assign ocd_win      = ocd_tx_valid & (sel_ocd1_cpu0 | ~cpu_tx_valid);
    assign cpu_win      = cpu_tx_valid & ~ocd_win;
    assign ocd_tx_ready = idle & ocd_win;
    assign cpu_tx_ready = idle & cpu_win;
    assign hs           = ocd_tx_ready | cpu_tx_ready;
    assign tick         = (cnt_q == '0);
    assign TXD          = txd_q;
    assign busy         = (state_q != IDLE);
    assign grant_ocd    = grant_q;
    // next-state: accept a byte in IDLE, then step start/data/stop bits on each baud tick; TXD follows the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? RELOAD : cnt_q - CW'(1);
        shreg_d = shreg_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (hs) begin
                    state_d = START;
                    cnt_d   = RELOAD;
                    shreg_d = ocd_win ? ocd_tx_data : cpu_tx_data;
                    grant_d = ocd_win;
                    idx_d   = '0;
                end
            end
            START: state_d = tick ? DATA : START;
            DATA: begin
                if (tick && idx_q == 3'd7) begin
                    state_d = STOP;
                end else if (tick) begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + 3'd1;
                end
            end
            STOP: state_d = tick ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
        txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : 1'b1;
    end
    // state registers; reset forces the line idle immediately and drops any in-flight byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
            grant_q <= grant_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench decoding TXD frames and checking arbitration and timing
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int BP = 4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sel = 1'b0;
    logic cv = 1'b0;
    logic ov = 1'b0;
    logic [7:0] cd = '0;
    logic [7:0] od = '0;
    logic cpu_tx_ready, ocd_tx_ready, TXD, busy, grant_ocd;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    typedef struct {logic g; logic [7:0] d;} exp_t;
    exp_t sb[$];
    int starts[$];

    uart_tx_arbiter #(.BAUD_PERIOD(BP)) dut (
        .clk(clk), .reset_n(reset_n), .sel_ocd1_cpu0(sel),
        .cpu_tx_valid(cv), .cpu_tx_data(cd), .cpu_tx_ready(cpu_tx_ready),
        .ocd_tx_valid(ov), .ocd_tx_data(od), .ocd_tx_ready(ocd_tx_ready),
        .TXD(TXD), .busy(busy), .grant_ocd(grant_ocd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input bit o, output int c);
        int n;
        c = -1;
        n = 0;
        while (c < 0 && n < 3000) begin
            #1;
            if (o ? ocd_tx_ready : cpu_tx_ready) c = cyc;
            else @(negedge clk);
            n++;
        end
        chk(o ? "ocd_ready_timeout" : "cpu_ready_timeout", 32'(c >= 0), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    // frame monitor: decodes 40 samples per frame and compares with the scoreboard
    initial begin : mon
        logic prev;
        logic s [40];
        logic ab, gl, bz, g, gs;
        logic [7:0] b;
        exp_t e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n && prev === 1'b1 && TXD === 1'b0) begin
                starts.push_back(cyc);
                ab = 1'b0; gl = 1'b0; bz = busy; g = grant_ocd; gs = 1'b1;
                s[0] = TXD;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    if (!reset_n) begin
                        ab = 1'b1;
                        break;
                    end
                    s[i] = TXD;
                    bz &= busy;
                    gs &= (grant_ocd === g);
                end
                if (!ab) begin
                    for (int k = 0; k < 10; k++)
                        for (int j = 1; j < 4; j++)
                            gl |= (s[4*k+j] !== s[4*k]);
                    for (int k = 0; k < 8; k++) b[k] = s[4*(k+1)];
                    chk("txd_glitch", gl, 0);
                    chk("start_bit", s[0], 0);
                    chk("stop_bit", s[36], 1);
                    chk("busy_in_frame", bz, 1);
                    chk("grant_stable", gs, 1);
                    if (sb.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("frame_data", b, e.d);
                        chk("frame_grant", g, e.g);
                    end
                end
            end
            prev = TXD;
        end
    end

    initial begin : main
        int c0, c1, c2, n;
        // reset, with a CPU request held to show no ready during reset
        cv = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd", TXD, 1);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_ocd, 0);
        chk("rst_cpu_ready", cpu_tx_ready, 0);
        cv = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_outputs", {TXD, busy, grant_ocd, cpu_tx_ready, ocd_tx_ready}, 5'b10000);
        end
        // single CPU byte 0xA5
        cd = 8'hA5; cv = 1'b1;
        sb.push_back('{1'b0, 8'hA5});
        wait_rdy(0, c0);
        chk("single_ocd_ready", ocd_tx_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("single_ready_after_hs", cpu_tx_ready, 0);
        chk("single_start_latency", TXD, 0);
        cv = 1'b0;
        n = busy ? 1 : 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n += busy ? 1 : 0;
        end
        chk("single_busy_len", n, 40);
        drain();
        // tie with OCD priority
        starts.delete();
        sel = 1'b1; od = 8'h3C; cd = 8'h5A;
        sb.push_back('{1'b1, 8'h3C});
        sb.push_back('{1'b0, 8'h5A});
        ov = 1'b1; cv = 1'b1;
        wait_rdy(1, c0);
        chk("tie_ocd_loser_ready", cpu_tx_ready, 0);
        @(posedge clk);
        @(negedge clk);
        ov = 1'b0;
        wait_rdy(0, c1);
        chk("tie_ocd_gap", c1 - c0, 41);
        @(posedge clk);
        @(negedge clk);
        cv = 1'b0;
        drain();
        chk("tie_ocd_starts", starts.size(), 2);
        if (starts.size() == 2) chk("tie_ocd_start_gap", starts[1] - starts[0], 41);
        // tie with CPU priority
        starts.delete();
        sel = 1'b0;
        sb.push_back('{1'b0, 8'h5A});
        sb.push_back('{1'b1, 8'h3C});
        ov = 1'b1; cv = 1'b1;
        wait_rdy(0, c0);
        chk("tie_cpu_loser_ready", ocd_tx_ready, 0);
        @(posedge clk);
        @(negedge clk);
        cv = 1'b0;
        wait_rdy(1, c1);
        chk("tie_cpu_gap", c1 - c0, 41);
        @(posedge clk);
        @(negedge clk);
        ov = 1'b0;
        drain();
        chk("tie_cpu_starts", starts.size(), 2);
        if (starts.size() == 2) chk("tie_cpu_start_gap", starts[1] - starts[0], 41);
        // sel toggling during a CPU 0xFF frame
        cd = 8'hFF; cv = 1'b1;
        sb.push_back('{1'b0, 8'hFF});
        wait_rdy(0, c0);
        @(posedge clk);
        @(negedge clk);
        cv = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (i % 3 == 0) sel = ~sel;
            @(negedge clk);
        end
        sel = 1'b0;
        drain();
        // reset in the middle of an OCD 0x00 frame
        od = 8'h00; ov = 1'b1;
        wait_rdy(1, c0);
        @(posedge clk);
        @(negedge clk);
        ov = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrst_txd_before", TXD, 0);
        chk("midrst_grant_before", grant_ocd, 1);
        #2;
        reset_n = 1'b0;
        cv = 1'b1;
        #1;
        chk("midrst_txd_async", TXD, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_cpu_ready", cpu_tx_ready, 0);
        chk("midrst_grant", grant_ocd, 0);
        cv = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cd = 8'h81; cv = 1'b1;
        sb.push_back('{1'b0, 8'h81});
        wait_rdy(0, c0);
        @(posedge clk);
        @(negedge clk);
        cv = 1'b0;
        drain();
        // streaming three CPU bytes with valid held high
        starts.delete();
        cd = 8'h01; cv = 1'b1;
        sb.push_back('{1'b0, 8'h01});
        sb.push_back('{1'b0, 8'h02});
        sb.push_back('{1'b0, 8'h03});
        wait_rdy(0, c0);
        @(posedge clk);
        @(negedge clk);
        cd = 8'h02;
        wait_rdy(0, c1);
        @(posedge clk);
        @(negedge clk);
        cd = 8'h03;
        wait_rdy(0, c2);
        @(posedge clk);
        @(negedge clk);
        cv = 1'b0;
        chk("stream_gap1", c1 - c0, 41);
        chk("stream_gap2", c2 - c1, 41);
        drain();
        chk("stream_starts", starts.size(), 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
